// File: rtl/stage4_mem_pkg.sv
// Shared EX/MEM/WB/ID stage-bus widths and field offsets, plus packed views of the buses MEM touches.
`ifndef STAGE_BUS_DEFINES
`define STAGE_BUS_DEFINES
`define WIDTH_ES_TO_MS_BUS 71
`define WIDTH_MS_TO_WS_BUS 70
`define WIDTH_MS_TO_DS_BUS 38
`define ES_PC_LSB          0
`define ES_GR_WE_BIT       32
`define ES_RES_MEM_BIT     33
`define ES_DEST_LSB        34
`define ES_ALU_LSB         39
`define MS_PC_LSB          0
`define MS_GR_WE_BIT       32
`define MS_DEST_LSB        33
`define MS_RESULT_LSB      38
`endif

package stage4_mem_pkg;

    localparam int ES_TO_MS_W = `WIDTH_ES_TO_MS_BUS;
    localparam int MS_TO_WS_W = `WIDTH_MS_TO_WS_BUS;
    localparam int MS_TO_DS_W = `WIDTH_MS_TO_DS_BUS;

    // Member order follows the bit layout, MSB first.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic        gr_we;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        gr_we_valid;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_to_ds_t;

endpackage

// File: rtl/stage4_mem.sv
// MEM pipeline stage: latches the EX bus, selects ALU or SRAM load data, and feeds WB and the ID bypass.
// One cycle EX-accept to WB-valid; load data is frozen in rd_hold so a WB stall never corrupts it.
module stage4_mem
    import stage4_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_allow_in,
    output logic                  ms_allow_in,
    input  logic                  es_to_ms_valid,
    output logic                  ms_to_ws_valid,
    input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
    input  logic [31:0]           data_sram_rdata,
    output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_W-1:0] ms_to_ds_bus
);

    es_to_ms_t   bus_r;
    ms_to_ws_t   ws_out;
    ms_to_ds_t   ds_out;
    logic        ms_valid;
    logic        ms_first;
    logic        ms_ready_go;
    logic        accept;
    logic [31:0] rd_hold;
    logic [31:0] mem_result;
    logic [31:0] final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
            ms_first <= 1'b0;
            rd_hold  <= 32'd0;
        end else begin
            if (ms_allow_in) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                bus_r <= es_to_ms_bus;
            end
            ms_first <= accept;
            if (ms_first) begin
                rd_hold <= data_sram_rdata;
            end
        end
    end

    // The SRAM port only reflects our address in the first cycle; afterwards EX owns it.
    assign mem_result   = ms_first ? data_sram_rdata : rd_hold;
    assign final_result = bus_r.res_from_mem ? mem_result : bus_r.alu_result;

    always_comb begin
        ws_out              = '0;
        ws_out.final_result = final_result;
        ws_out.dest         = bus_r.dest;
        ws_out.gr_we        = bus_r.gr_we;
        ws_out.pc           = bus_r.pc;

        ds_out              = '0;
        ds_out.gr_we_valid  = bus_r.gr_we && ms_valid;
        ds_out.dest         = bus_r.dest;
        ds_out.final_result = final_result;
    end

    assign ms_to_ws_bus = ws_out;
    assign ms_to_ds_bus = ds_out;

endmodule

// File: doc/stage4_mem.md
Name: stage4_MEM

Overview:
Fourth pipeline stage, directly downstream of stage3_EX and upstream of stage5_WB.
- Latches the EX→MEM bus under a valid/allow-in handshake.
- Picks the writeback value: ALU result, or load data from the synchronous data SRAM.
- Forwards the result to ID for bypass and to WB for register write.
- Holds load data stable across WB back-pressure.

Parameters:
None. Bus widths come from the shared `define header: WIDTH_ES_TO_MS_BUS=71, WIDTH_MS_TO_WS_BUS=70, WIDTH_MS_TO_DS_BUS=38.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ws_allow_in  input  1  WB can accept this cycle
ms_allow_in  output  1  MEM can accept this cycle
es_to_ms_valid  input  1  EX presents a valid instruction
ms_to_ws_valid  output  1  MEM presents a valid instruction to WB
es_to_ms_bus  input  71  [31:0] pc, [32] gr_we, [33] res_from_mem, [38:34] dest, [70:39] alu_result
data_sram_rdata  input  32  read data; valid the cycle after EX drove the address
ms_to_ws_bus  output  70  [31:0] pc, [32] gr_we, [37:33] dest, [69:38] final_result
ms_to_ds_bus  output  38  {gr_we_valid, dest[4:0], final_result[31:0]} for ID bypass/hazard

Behaviour:
- Handshake: ms_ready_go=1. ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in). ms_to_ws_valid = ms_valid && ms_ready_go.
- ms_valid:
  - reset → 0.
  - Else when ms_allow_in, ms_valid ← es_to_ms_valid.
  - Else hold.
- Bus register:
  - reset → 0.
  - Loads es_to_ms_bus only when es_to_ms_valid && ms_allow_in.
  - Otherwise holds (no zeroing on bubble).
- First-cycle flag ms_first:
  - reset → 0.
  - Set to 1 on the cycle the bus register loads; cleared on every other cycle.
- Load-data hold register rd_hold (32b):
  - reset → 0.
  - Captures data_sram_rdata when ms_first=1; holds otherwise.
- mem_result = ms_first ? data_sram_rdata : rd_hold. The SRAM output is only trusted in the cycle right after the address; later cycles reflect whatever EX addresses next.
- final_result = res_from_mem ? mem_result : alu_result.
- ms_to_ws_bus = {final_result, dest, gr_we, pc}. It is meaningful only when ms_to_ws_valid=1; WB qualifies it with valid.
- ms_to_ds_bus gr_we field = gr_we && ms_valid, so a stale register never creates a false bypass. A dest of 0 is passed through; ID ignores r0.
- Latency: one cycle from EX acceptance to ms_to_ws_valid.
- Stall: when ms_valid && !ws_allow_in, all outputs are stable cycle-to-cycle, including load results.
- Simultaneous exit and entry: when ws_allow_in=1 and es_to_ms_valid=1, the new instruction replaces the old one in the same edge with no bubble.
- Reset mid-operation: the instruction is discarded. ms_valid=0 and ms_to_ds_bus gr_we field=0 in the cycle after reset is sampled.
- Reset values of all outputs: ms_to_ws_valid=0, ms_allow_in=1, ms_to_ws_bus=0, ms_to_ds_bus=0.

Decomposition:
- Widths stay in the shared `define header next to the other stage-bus widths. Bus field offsets go there as named constants.
- No sub-module: the load-data hold logic is small and stays inline.

Test Plan:
- Non-load pass-through:
  - Stimulus: pc=0x1C000010, gr_we=1, dest=5, alu_result=0x00000042, res_from_mem=0; ws_allow_in=1.
  - Response: next cycle ms_to_ws_valid=1, final_result=0x42, ms_to_ds_bus={1,5,0x42}.
- Load, no stall:
  - Stimulus: res_from_mem=1, dest=7; rdata=0xDEADBEEF in the cycle after acceptance.
  - Response: final_result=0xDEADBEEF.
- Load under back-pressure:
  - Stimulus: same load as above; ws_allow_in=0 for 3 cycles; rdata changes to 0x11111111 after the first cycle.
  - Response: final_result stays 0xDEADBEEF; ms_allow_in=0 throughout; output is released when ws_allow_in=1.
- Back-to-back:
  - Stimulus: two valid instructions on consecutive cycles with ws_allow_in=1.
  - Response: two consecutive ms_to_ws_valid pulses with the correct distinct pcs; no bubble.
- Bubble:
  - Stimulus: es_to_ms_valid=0 after a valid instruction.
  - Response: ms_valid=0; ms_to_ds_bus[37]=0 even though the bus register keeps the old dest.
- Reset mid-stall:
  - Stimulus: assert reset while a load is stalled.
  - Response: ms_to_ws_valid=0, ms_to_ds_bus=0, ms_allow_in=1 on the next cycle.
